// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and the
// three-sample majority vote used for every bit decision.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;
  localparam int DATA_BITS  = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head word is read combinationally
// from the storage array. A pop on a full FIFO frees room for a same-cycle push.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: 16x oversampling with mid-bit majority vote, feeding a
// byte FIFO. Flags framing errors and sticky overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_en,
  input  logic             data_in,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             rd,
  output logic [7:0]       data_out,
  output logic             empty,
  output logic             full,
  output logic             done,
  output logic             err,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_DATA  = DATA;
  localparam logic [1:0] ST_STOP  = STOP;

  logic             sync1;
  logic             rxs;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_eff;
  logic             tick;
  logic [1:0]       state;
  logic [3:0]       s;
  logic [2:0]       b;
  logic [1:0]       smp;
  logic             start_vote;
  logic [7:0]       shreg;
  logic             vote;
  logic             start_det;
  logic             stop_eval;
  logic             push_frame;
  logic             frame_err;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= data_in;
      rxs   <= sync1;
    end
  end

  assign div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign tick    = (cnt == div_eff - DIV_W'(1));

  // Restarting the divider at the detected edge centres the samples in each bit.
  assign start_det = rx_en && (state == ST_IDLE) && !rxs;

  always_ff @(posedge clk) begin
    if (rst || start_det || tick) cnt <= '0;
    else                          cnt <= cnt + DIV_W'(1);
  end

  // Samples 7 and 8 are stored; the vote completes with the live sample 9.
  assign vote       = maj3(smp[0], smp[1], rxs);
  assign stop_eval  = rx_en && (state == ST_STOP) && tick && (s == 4'(SAMPLE_HI));
  assign push_frame = stop_eval && vote;
  assign frame_err  = stop_eval && !vote;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      s          <= '0;
      b          <= '0;
      smp        <= '0;
      start_vote <= 1'b1;
      shreg      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= push_frame;
      err  <= frame_err;
      if (!rx_en) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!rxs) begin
              state <= ST_START;
              s     <= '0;
            end
          end
          ST_START, ST_DATA, ST_STOP: begin
            if (tick) begin
              s <= s + 4'd1;
              if (s == 4'(SAMPLE_LO))  smp[0] <= rxs;
              if (s == 4'(SAMPLE_MID)) smp[1] <= rxs;
              if (s == 4'(SAMPLE_HI)) begin
                if (state == ST_START) start_vote <= vote;
                if (state == ST_DATA)  shreg      <= {vote, shreg[7:1]};
                if (state == ST_STOP)  state      <= ST_IDLE;
              end
              if (s == 4'(OVERSAMPLE - 1)) begin
                if (state == ST_START) begin
                  if (!start_vote) begin
                    state <= ST_DATA;
                    b     <= '0;
                  end else begin
                    state <= ST_IDLE;
                  end
                end else if (state == ST_DATA) begin
                  if (b == 3'(DATA_BITS - 1)) state <= ST_STOP;
                  else                        b     <= b + 3'd1;
                end
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // A pop while full frees a slot, so only an unpopped full FIFO drops the byte.
  always_ff @(posedge clk) begin
    if (rst)                             overflow <= 1'b0;
    else if (push_frame && full && !rd)  overflow <= 1'b1;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_frame),
    .wdata (shreg),
    .pop   (rd),
    .rdata (data_out),
    .full  (full),
    .empty (empty)
  );

endmodule
